// File: rtl/lsu_dmem_port.sv
// lsu_dmem_port: load/store back end between the execute stage and data BRAM port B.
// Latency: response 2 cycles after the accept cycle (1 cycle for rejected requests); 1 request per 3 cycles.
// Backpressure: req_ready low outside IDLE or while BRAM reset is busy; response held until rsp_ready.
module lsu_dmem_port #(
  parameter int MEM_DEPTH = 4096,
  parameter int N_param   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_param-1:0] memory_offset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [1:0]         req_size,
  input  logic               req_unsigned,
  input  logic [N_param-1:0] req_addr,
  input  logic [N_param-1:0] req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [N_param-1:0] rsp_rdata,
  output logic               rsp_err,
  output logic               data_mem_clkb,
  output logic               data_mem_enb,
  output logic               data_mem_rstb,
  output logic [3:0]         data_mem_web,
  output logic [N_param-1:0] data_mem_addrb,
  output logic [N_param-1:0] data_mem_dinb,
  input  logic [N_param-1:0] data_mem_doutb,
  input  logic               data_mem_rstb_busy
);

  localparam logic [N_param-1:0] DEPTH_W = N_param'(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic               accept, req_bad, issue;
  logic [N_param-1:0] off;
  logic               lat_we, lat_unsigned;
  logic [1:0]         lat_size, lat_lane;
  logic [N_param-1:0] addrb_q, dinb_q;
  logic [3:0]         web_new;
  logic [N_param-1:0] dinb_new;
  logic [N_param-1:0] load_data;
  logic [7:0]         lane_b;
  logic [15:0]        lane_h;

  // Offset is taken modulo 2^32, so addresses below memory_offset wrap far out of range.
  assign off           = req_addr - memory_offset;
  assign req_ready     = (state_q == IDLE) & ~data_mem_rstb_busy & ~reset;
  assign accept        = req_valid & req_ready;
  assign issue         = accept & ~req_bad;
  assign data_mem_rstb = 1'b0;
  assign data_mem_clkb = clk;

  // Request legality: size encoding, natural alignment, BRAM range
  always_comb begin
    req_bad = 1'b0;
    case (req_size)
      2'b01:   req_bad = req_addr[0];
      2'b10:   req_bad = |req_addr[1:0];
      2'b11:   req_bad = 1'b1;
      default: req_bad = 1'b0;
    endcase
    if ({2'b00, off[N_param-1:2]} >= DEPTH_W) req_bad = 1'b1;
  end

  // Store byte enables and lane-replicated write data
  always_comb begin
    web_new  = 4'b0000;
    dinb_new = '0;
    if (req_we) begin
      case (req_size)
        2'b00: begin
          web_new  = 4'b0001 << off[1:0];
          dinb_new = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          web_new  = off[1] ? 4'b1100 : 4'b0011;
          dinb_new = {2{req_wdata[15:0]}};
        end
        default: begin
          web_new  = 4'b1111;
          dinb_new = req_wdata;
        end
      endcase
    end
  end

  // Load lane select and sign/zero extension of the BRAM read word
  always_comb begin
    load_data = '0;
    lane_b    = data_mem_doutb[{lat_lane, 3'b000} +: 8];
    lane_h    = lat_lane[1] ? data_mem_doutb[31:16] : data_mem_doutb[15:0];
    if (!lat_we) begin
      case (lat_size)
        2'b00:   load_data = {{24{~lat_unsigned & lane_b[7]}}, lane_b};
        2'b01:   load_data = {{16{~lat_unsigned & lane_h[15]}}, lane_h};
        default: load_data = data_mem_doutb;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: rejected requests skip the BRAM read cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = req_bad ? RESP : WAIT;
      WAIT:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: BRAM port is driven in the accept cycle, address/data hold otherwise
  always_comb begin
    rsp_valid      = (state_q == RESP);
    data_mem_enb   = issue;
    data_mem_web   = issue ? web_new : 4'b0000;
    data_mem_addrb = issue ? {off[N_param-1:2], 2'b00} : addrb_q;
    data_mem_dinb  = issue ? dinb_new : dinb_q;
  end

  // Request latches and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      addrb_q      <= '0;
      dinb_q       <= '0;
      lat_we       <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_size     <= 2'b00;
      lat_lane     <= 2'b00;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
    end else begin
      if (issue) begin
        addrb_q      <= data_mem_addrb;
        dinb_q       <= data_mem_dinb;
        lat_we       <= req_we;
        lat_unsigned <= req_unsigned;
        lat_size     <= req_size;
        lat_lane     <= off[1:0];
      end
      if (accept && req_bad) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
      end else if (state_q == WAIT) begin
        rsp_rdata <= load_data;
        rsp_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_dmem_port.sv
// tb_lsu_dmem_port: exercises lsu_dmem_port against a BRAM model and a byte-level memory model.
// Latency: checks 2-edge responses for legal requests and 1-edge responses for rejected ones.
// Backpressure: holds rsp_ready low and asserts data_mem_rstb_busy to check stalls.
module tb_lsu_dmem_port;

  localparam logic [31:0] OFFSET = 32'h0000_0600;

  logic        tb_clk = 1'b0;
  logic        rstb;  // active-high, drives the DUT synchronous reset
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        data_mem_clkb, data_mem_enb, data_mem_rstb, data_mem_rstb_busy;
  logic [3:0]  data_mem_web;
  logic [31:0] data_mem_addrb, data_mem_dinb, data_mem_doutb;

  int total = 0;
  int bad   = 0;
  int enb_cnt = 0;
  int acc_cnt = 0;

  always #5 tb_clk = ~tb_clk;

  lsu_dmem_port #(.MEM_DEPTH(4096), .N_param(32)) dut (
    .clk(tb_clk), .reset(rstb), .memory_offset(OFFSET),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .data_mem_clkb(data_mem_clkb), .data_mem_enb(data_mem_enb), .data_mem_rstb(data_mem_rstb),
    .data_mem_web(data_mem_web), .data_mem_addrb(data_mem_addrb), .data_mem_dinb(data_mem_dinb),
    .data_mem_doutb(data_mem_doutb), .data_mem_rstb_busy(data_mem_rstb_busy)
  );

  // BRAM port B model: registered read (old data), per-byte writes
  logic [31:0] bram [0:4095];
  logic [31:0] bram_rd, bram_merged;
  logic        bram_clear;
  assign bram_rd = bram[data_mem_addrb[13:2]];
  always_comb begin
    bram_merged = bram_rd;
    for (int b = 0; b < 4; b++)
      if (data_mem_web[b]) bram_merged[8*b +: 8] = data_mem_dinb[8*b +: 8];
  end
  always @(posedge data_mem_clkb) begin
    if (bram_clear) begin
      for (int i = 0; i < 4096; i++) bram[i] <= '0;
      data_mem_doutb <= '0;
    end else if (data_mem_enb) begin
      data_mem_doutb <= bram_rd;
      bram[data_mem_addrb[13:2]] <= bram_merged;
    end
  end

  // Activity monitors, sampled mid-cycle
  always @(negedge tb_clk) begin
    if (data_mem_enb) enb_cnt++;
    if (req_valid && req_ready) acc_cnt++;
  end

  // Reference memory: plain byte array indexed by (address - offset)
  logic [7:0] ref_mem [0:16383];

  function automatic logic exp_err(input logic [1:0] size, input logic [31:0] addr);
    logic [31:0] off;
    off = addr - OFFSET;
    if (size == 2'd3) return 1'b1;
    if (size == 2'd1 && (addr % 2) != 0) return 1'b1;
    if (size == 2'd2 && (addr % 4) != 0) return 1'b1;
    return (off / 4) >= 4096;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns, input logic [31:0] addr);
    logic [31:0] off;
    int nb;
    longint v;
    off = addr - OFFSET;
    nb = 1 << size;
    v = 0;
    for (int i = 0; i < nb; i++) v += longint'(ref_mem[off + i]) << (8 * i);
    if (!uns && v >= (longint'(1) << (8 * nb - 1))) v -= longint'(1) << (8 * nb);
    return 32'(v);
  endfunction

  task automatic ref_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] off;
    off = addr - OFFSET;
    for (int i = 0; i < (1 << size); i++) ref_mem[off + i] = 8'(wdata >> (8 * i));
  endtask

  // Issue one request from posedge+1; returns once rsp_valid is seen (and consumed if rsp_ready)
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int edges,
                        output logic [3:0] web_s, output logic [31:0] addrb_s,
                        output logic [31:0] dinb_s, output logic enb_s);
    int guard;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(posedge tb_clk); #1;
      guard++;
    end
    total++;
    if (!req_ready) begin
      bad++;
      $display("FAIL req_ready_wait got=%b exp=1", req_ready);
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    #1;
    enb_s = data_mem_enb; web_s = data_mem_web; addrb_s = data_mem_addrb; dinb_s = data_mem_dinb;
    @(posedge tb_clk); #1;
    req_valid = 1'b0;
    edges = 1;
    while (!rsp_valid && edges < 10) begin
      @(posedge tb_clk); #1;
      edges++;
    end
    rdata = rsp_rdata;
    err = rsp_err;
    if (rsp_ready) begin
      @(posedge tb_clk); #1;
    end
  endtask

  task automatic test_reset;
    rstb = 1'b1; bram_clear = 1'b1; data_mem_rstb_busy = 1'b0; rsp_ready = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 16384; i++) ref_mem[i] = 8'h00;
    repeat (3) @(posedge tb_clk);
    #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rsp_rdata got=%h exp=0", rsp_rdata); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL rst_rsp_err got=%b exp=0", rsp_err); end
    total++; if (data_mem_enb !== 1'b0 || data_mem_web !== 4'h0) begin bad++; $display("FAIL rst_enb_web got=%b/%h exp=0/0", data_mem_enb, data_mem_web); end
    total++; if (data_mem_addrb !== 32'h0 || data_mem_dinb !== 32'h0) begin bad++; $display("FAIL rst_addr_din got=%h/%h exp=0/0", data_mem_addrb, data_mem_dinb); end
    total++; if (data_mem_rstb !== 1'b0) begin bad++; $display("FAIL rst_bram_rstb got=%b exp=0", data_mem_rstb); end
    bram_clear = 1'b0;
    rstb = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", req_ready); end
    @(posedge tb_clk); #1;
  endtask

  task automatic test_word;
    logic [31:0] rd, ab, db; logic er, en; int ed; logic [3:0] wb;
    do_req(1'b1, 2'd2, 1'b0, 32'h608, 32'hDEADBEEF, rd, er, ed, wb, ab, db, en);
    ref_store(2'd2, 32'h608, 32'hDEADBEEF);
    total++; if (ab !== 32'h8) begin bad++; $display("FAIL sw_addrb got=%h exp=00000008", ab); end
    total++; if (wb !== 4'b1111 || en !== 1'b1) begin bad++; $display("FAIL sw_web got=%b en=%b exp=1111 en=1", wb, en); end
    total++; if (db !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_dinb got=%h exp=deadbeef", db); end
    total++; if (ed !== 2 || er !== 1'b0 || rd !== 32'h0) begin bad++; $display("FAIL sw_rsp got=edges%0d err%b %h exp=edges2 err0 0", ed, er, rd); end
    do_req(1'b0, 2'd2, 1'b0, 32'h608, 32'h0, rd, er, ed, wb, ab, db, en);
    total++; if (wb !== 4'b0000 || db !== 32'h0 || ab !== 32'h8) begin bad++; $display("FAIL lw_port got=%b %h %h exp=0000 0 8", wb, db, ab); end
    total++; if (rd !== 32'hDEADBEEF || ed !== 2 || er !== 1'b0) begin bad++; $display("FAIL lw_data got=%h edges%0d err%b exp=deadbeef edges2 err0", rd, ed, er); end
  endtask

  task automatic test_byte_half;
    logic [31:0] rd, ab, db; logic er, en; int ed; logic [3:0] wb;
    do_req(1'b1, 2'd0, 1'b0, 32'h60D, 32'h0000_0080, rd, er, ed, wb, ab, db, en);
    ref_store(2'd0, 32'h60D, 32'h80);
    total++; if (wb !== 4'b0010 || db !== 32'h80808080 || ab !== 32'hC) begin bad++; $display("FAIL sb_port got=%b %h %h exp=0010 80808080 c", wb, db, ab); end
    do_req(1'b0, 2'd0, 1'b0, 32'h60D, 32'h0, rd, er, ed, wb, ab, db, en);
    total++; if (rd !== 32'hFFFFFF80) begin bad++; $display("FAIL lb got=%h exp=ffffff80", rd); end
    do_req(1'b0, 2'd0, 1'b1, 32'h60D, 32'h0, rd, er, ed, wb, ab, db, en);
    total++; if (rd !== 32'h00000080) begin bad++; $display("FAIL lbu got=%h exp=00000080", rd); end
    do_req(1'b1, 2'd1, 1'b0, 32'h612, 32'h1234_8001, rd, er, ed, wb, ab, db, en);
    ref_store(2'd1, 32'h612, 32'h1234_8001);
    total++; if (wb !== 4'b1100 || db !== 32'h80018001) begin bad++; $display("FAIL sh_port got=%b %h exp=1100 80018001", wb, db); end
    do_req(1'b0, 2'd1, 1'b0, 32'h612, 32'h0, rd, er, ed, wb, ab, db, en);
    total++; if (rd !== 32'hFFFF8001) begin bad++; $display("FAIL lh got=%h exp=ffff8001", rd); end
    do_req(1'b0, 2'd1, 1'b1, 32'h612, 32'h0, rd, er, ed, wb, ab, db, en);
    total++; if (rd !== 32'h00008001) begin bad++; $display("FAIL lhu got=%h exp=00008001", rd); end
  endtask

  task automatic test_errors;
    logic [1:0]  sz [5] = '{2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
    logic [31:0] ad [5] = '{32'h601, 32'h603, 32'h5FC, 32'h600 + 32'd16384, 32'h608};
    logic [31:0] rd, ab, db; logic er, en; int ed, e0; logic [3:0] wb;
    for (int k = 0; k < 5; k++) begin
      e0 = enb_cnt;
      do_req(k[0], sz[k], 1'b0, ad[k], 32'hFFFF_FFFF, rd, er, ed, wb, ab, db, en);
      total++; if (er !== 1'b1 || ed !== 1) begin bad++; $display("FAIL err%0d_rsp got=err%b edges%0d exp=err1 edges1", k, er, ed); end
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL err%0d_rdata got=%h exp=0", k, rd); end
      total++; if (en !== 1'b0 || enb_cnt !== e0) begin bad++; $display("FAIL err%0d_enb got=%b cnt%0d exp=0 cnt%0d", k, en, enb_cnt, e0); end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] rd, ab, db; logic er, en; int ed; logic [3:0] wb;
    rsp_ready = 1'b0;
    do_req(1'b0, 2'd2, 1'b0, 32'h608, 32'h0, rd, er, ed, wb, ab, db, en);
    for (int c = 0; c < 5; c++) begin
      @(posedge tb_clk); #1;
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== ref_load(2'd2, 1'b0, 32'h608) || req_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d got=v%b %h rdy%b exp=v1 %h rdy0", c, rsp_valid, rsp_rdata, req_ready, ref_load(2'd2, 1'b0, 32'h608));
      end
    end
    rsp_ready = 1'b1;
    @(posedge tb_clk); #1;
    total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=v%b rdy%b exp=v0 rdy1", rsp_valid, req_ready); end
  endtask

  task automatic test_back_to_back;
    int a0;
    a0 = acc_cnt;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h608;
    repeat (12) @(posedge tb_clk);
    #1;
    req_valid = 1'b0;
    total++; if (acc_cnt - a0 !== 4) begin bad++; $display("FAIL b2b_accepts got=%0d exp=4", acc_cnt - a0); end
  endtask

  task automatic test_reset_mid;
    int e0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h60C;
    @(posedge tb_clk); #1;
    req_valid = 1'b0;
    rstb = 1'b1;
    @(posedge tb_clk); #1;
    total++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin bad++; $display("FAIL midrst_rsp got=v%b %h e%b exp=v0 0 e0", rsp_valid, rsp_rdata, rsp_err); end
    total++; if (data_mem_enb !== 1'b0 || data_mem_web !== 4'h0 || data_mem_addrb !== 32'h0 || data_mem_dinb !== 32'h0) begin bad++; $display("FAIL midrst_port got=%b %h %h %h exp=0 0 0 0", data_mem_enb, data_mem_web, data_mem_addrb, data_mem_dinb); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready got=%b exp=0", req_ready); end
    rstb = 1'b0;
    @(posedge tb_clk); #1;
    total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL midrst_idle got=v%b rdy%b exp=v0 rdy1", rsp_valid, req_ready); end
    data_mem_rstb_busy = 1'b1;
    #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL busy_ready got=%b exp=0", req_ready); end
    e0 = enb_cnt;
    req_valid = 1'b1; req_addr = 32'h608;
    repeat (3) @(posedge tb_clk);
    #1;
    total++; if (enb_cnt !== e0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL busy_block got=cnt%0d v%b exp=cnt%0d v0", enb_cnt, rsp_valid, e0); end
    req_valid = 1'b0;
    data_mem_rstb_busy = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL busy_release got=%b exp=1", req_ready); end
  endtask

  task automatic test_random;
    logic [31:0] rd, ab, db, addr, wdata, exp_rd; logic er, en, we, uns, ee; int ed; logic [3:0] wb; logic [1:0] size;
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom % 2);
      uns = 1'($urandom % 2);
      size = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      wdata = $urandom;
      case ($urandom % 8)
        0:       addr = OFFSET - $urandom_range(1, 16);
        1:       addr = OFFSET + 32'd16384 + $urandom_range(0, 64);
        2, 3:    addr = OFFSET + $urandom_range(0, 16383);
        default: addr = OFFSET + $urandom_range(0, 63);
      endcase
      if ($urandom % 4 != 0) begin
        if (size == 2'd1) addr[0] = 1'b0;
        if (size == 2'd2) addr[1:0] = 2'b00;
      end
      ee = exp_err(size, addr);
      exp_rd = (ee || we) ? 32'h0 : ref_load(size, uns, addr);
      do_req(we, size, uns, addr, wdata, rd, er, ed, wb, ab, db, en);
      if (!ee && we) ref_store(size, addr, wdata);
      total++;
      if (er !== ee || rd !== exp_rd || ed !== (ee ? 1 : 2) || en !== !ee) begin
        bad++;
        $display("FAIL rand%0d we%b sz%0d a=%h got=err%b %h edges%0d en%b exp=err%b %h edges%0d en%b",
                 n, we, size, addr, er, rd, ed, en, ee, exp_rd, ee ? 1 : 2, !ee);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
